// File: rtl/weight_updater_tiled_pkg.sv
// Shared definitions for the tiled weight updater.
//   state_t  : controller states (IDLE, RUN, DRAIN)
//   ceil_div : number of lane groups needed to cover the weight matrix
//   sat_max / sat_min : clamp limits for a signed weight of the given width
package weight_updater_tiled_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  function automatic longint sat_max(input int ww);
    return (longint'(1) << (ww - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int ww);
    return -(longint'(1) << (ww - 1));
  endfunction

endpackage

// File: rtl/weight_updater_tiled_update_lane.sv
// update_lane: stage-2 datapath for one cell, purely combinational.
//   prod     : registered signed product delta[i]*a[j] (2*AW bits)
//   w_old    : registered old weight
//   lr_shift : learning-rate right shift
//   w_new    : saturated updated weight
//   clamp    : high when w_new was clamped
module update_lane
  import weight_updater_tiled_pkg::*;
#(
  parameter int AW    = 8,
  parameter int WW    = 16,
  parameter int SW    = 4,
  parameter int ROUND = 1
) (
  input  logic signed [2*AW-1:0] prod,
  input  logic signed [WW-1:0]   w_old,
  input  logic        [SW-1:0]   lr_shift,
  output logic signed [WW-1:0]   w_new,
  output logic                   clamp
);

  // One guard bit so the rounding bias can never overflow the product.
  localparam int PW = 2*AW + 1;
  // Wide enough that the subtraction itself never wraps; clamp after.
  localparam int DW = ((WW > PW) ? WW : PW) + 1;
  localparam logic signed [WW-1:0] W_MAX = WW'(sat_max(WW));
  localparam logic signed [WW-1:0] W_MIN = WW'(sat_min(WW));

  logic signed [PW-1:0] p_ext, bias, shifted;
  logic signed [DW-1:0] diff;
  logic                 big_shift;

  always_comb begin
    big_shift = 32'(lr_shift) >= 32'(2*AW);
    p_ext     = PW'(prod);
    bias      = '0;
    if (ROUND != 0 && lr_shift != '0 && !big_shift)
      bias = PW'(1) << (lr_shift - 1'b1);
    // Shifting everything out leaves only the sign (floor) or zero (rounded).
    if (big_shift)
      shifted = (ROUND != 0 || !prod[2*AW-1]) ? '0 : '1;
    else
      shifted = (p_ext + bias) >>> lr_shift;
    diff  = DW'(w_old) - DW'(shifted);
    // In range iff all bits above the weight's sign bit match it.
    clamp = diff[DW-1:WW-1] != {(DW-WW+1){diff[DW-1]}};
    w_new = clamp ? (diff[DW-1] ? W_MIN : W_MAX) : diff[WW-1:0];
  end

endmodule

// File: rtl/weight_updater_tiled.sv
// weight_updater_tiled: w_new[i][j] = sat(w[i][j] - round((delta[i]*a[j]) >>> lr_shift))
// over an OUT_NUM x IN_NUM matrix, LANES cells per cycle, two pipeline stages.
//   clk, rst  : clock, synchronous active-high reset
//   start     : request, accepted only when idle; latches a, delta, w, lr_shift
//   lr_shift  : learning-rate shift
//   a, delta  : signed activations / deltas, element n at [n*AW +: AW]
//   w, result : signed weights, cell k = i*IN_NUM + j at [k*WW +: WW]
//   busy      : accepted start until finish edge
//   finish    : one-cycle done pulse
//   valid     : result complete, until next accepted start
//   sat       : some cell clamped during the last operation
module weight_updater_tiled
  import weight_updater_tiled_pkg::*;
#(
  parameter int IN_NUM           = 5,
  parameter int OUT_NUM          = 5,
  parameter int ACTIVATION_WIDTH = 8,
  parameter int WEIGHT_WIDTH     = 16,
  parameter int LANES            = 4,
  parameter int SHIFT_WIDTH      = 4,
  parameter int ROUND            = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [SHIFT_WIDTH-1:0]                  lr_shift,
  input  logic [IN_NUM*ACTIVATION_WIDTH-1:0]      a,
  input  logic [OUT_NUM*ACTIVATION_WIDTH-1:0]     delta,
  input  logic [IN_NUM*OUT_NUM*WEIGHT_WIDTH-1:0]  w,
  output logic [IN_NUM*OUT_NUM*WEIGHT_WIDTH-1:0]  result,
  output logic                                    busy,
  output logic                                    finish,
  output logic                                    valid,
  output logic                                    sat
);

  localparam int AW   = ACTIVATION_WIDTH;
  localparam int WW   = WEIGHT_WIDTH;
  localparam int PWID = 2*AW;
  localparam int N    = IN_NUM*OUT_NUM;
  localparam int C    = ceil_div(N, LANES);
  localparam int GW   = (C > 1) ? $clog2(C) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(C - 1);

  state_t                     state, state_d;
  logic [GW-1:0]              grp, grp_d, grp_s2;
  logic                       s2_vld;      // stage-1 registers hold a live group
  logic                       accept;
  logic [SHIFT_WIDTH-1:0]     lr_q;
  logic [IN_NUM-1:0][AW-1:0]  a_q;
  logic [OUT_NUM-1:0][AW-1:0] d_q;
  logic [N-1:0][WW-1:0]       w_q;
  logic [N-1:0][WW-1:0]       res_q;
  logic [LANES-1:0][WW-1:0]   wnew;
  logic [LANES-1:0]           clamp, lane_live;

  assign accept = start && state == IDLE;
  assign result = res_q;

  // Controller
  always_comb begin
    state_d = state;
    grp_d   = grp;
    case (state)
      IDLE:    if (start) begin state_d = RUN; grp_d = '0; end
      RUN:     if (grp == G_LAST) state_d = DRAIN;
               else grp_d = grp + 1'b1;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grp   <= '0;
    end else begin
      state <= state_d;
      grp   <= grp_d;
    end
  end

  // Per-lane stage 1 (operand select + multiply) feeding stage 2 (update_lane)
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [AW-1:0] d_sel, a_sel;
    logic [WW-1:0]        w_sel;
    logic                 live;
    logic [PWID-1:0]      prod_r;
    logic [WW-1:0]        wold_r;
    logic                 live_r;

    always_comb begin
      int k;
      k     = int'(grp) * LANES + l;
      live  = k < N;
      d_sel = '0;
      a_sel = '0;
      w_sel = '0;
      for (int i = 0; i < OUT_NUM; i++) if (k / IN_NUM == i) d_sel = d_q[i];
      for (int j = 0; j < IN_NUM; j++)  if (k % IN_NUM == j) a_sel = a_q[j];
      for (int c = 0; c < N; c++)       if (k == c)          w_sel = w_q[c];
    end

    always_ff @(posedge clk) begin
      if (state == RUN) begin
        prod_r <= PWID'(d_sel) * PWID'(a_sel);
        wold_r <= w_sel;
        live_r <= live;
      end
    end

    assign lane_live[l] = live_r;

    update_lane #(.AW(AW), .WW(WW), .SW(SHIFT_WIDTH), .ROUND(ROUND)) u_lane (
      .prod     (prod_r),
      .w_old    (wold_r),
      .lr_shift (lr_q),
      .w_new    (wnew[l]),
      .clamp    (clamp[l])
    );
  end

  // Input latch, stage-2 writeback and handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= '0;
      busy   <= 1'b0;
      finish <= 1'b0;
      valid  <= 1'b0;
      sat    <= 1'b0;
      s2_vld <= 1'b0;
      grp_s2 <= '0;
      lr_q   <= '0;
    end else begin
      s2_vld <= state == RUN;
      finish <= state == DRAIN;   // DRAIN lasts one cycle -> one-cycle pulse
      if (state == RUN) grp_s2 <= grp;
      if (accept) begin
        lr_q  <= lr_shift;
        a_q   <= a;
        d_q   <= delta;
        w_q   <= w;
        busy  <= 1'b1;
        valid <= 1'b0;
        sat   <= 1'b0;
      end
      // Last group is written on this same edge.
      if (state == DRAIN) begin
        busy  <= 1'b0;
        valid <= 1'b1;
      end
      if (s2_vld) begin
        for (int l = 0; l < LANES; l++)
          for (int c = 0; c < N; c++)
            if (lane_live[l] && int'(grp_s2) * LANES + l == c) res_q[c] <= wnew[l];
        if (|(clamp & lane_live)) sat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_weight_updater_tiled.sv
// Self-checking bench: four builds (3x2 with LANES 4/1/6, ROUND 1/0/1, and the
// default 5x5) share the data inputs and have separate starts. A reference
// model predicts the cycle-level handshake and pushes expected matrices into
// per-build queues; the checker pops them whenever a build raises finish.
module tb_weight_updater_tiled;
  localparam int AW = 8, WW = 16, SW = 4, NI = 4, MAXN = 25, MAXW = MAXN*WW;
  localparam int CIN [NI] = '{3, 3, 3, 5};
  localparam int COUT[NI] = '{2, 2, 2, 5};
  localparam int CL  [NI] = '{4, 1, 6, 4};
  localparam int CR  [NI] = '{1, 0, 1, 1};
  localparam longint SMAX = (longint'(1) << (WW-1)) - 1;
  localparam longint SMIN = -(longint'(1) << (WW-1));

  logic            clk = 1'b0, rst;
  logic [NI-1:0]   start;
  logic [SW-1:0]   lr;
  logic [5*AW-1:0] a_all, d_all;
  logic [MAXW-1:0] w_all;
  logic [NI-1:0]   busy_o, fin_o, val_o, sat_o;
  logic [6*WW-1:0] r0, r1, r2;
  logic [MAXW-1:0] r3;
  logic [MAXW-1:0] res_o[NI];

  always #5 clk = ~clk;

  weight_updater_tiled #(.IN_NUM(3), .OUT_NUM(2), .LANES(4), .ROUND(1)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .lr_shift(lr), .a(a_all[3*AW-1:0]),
    .delta(d_all[2*AW-1:0]), .w(w_all[6*WW-1:0]), .result(r0),
    .busy(busy_o[0]), .finish(fin_o[0]), .valid(val_o[0]), .sat(sat_o[0]));
  weight_updater_tiled #(.IN_NUM(3), .OUT_NUM(2), .LANES(1), .ROUND(0)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .lr_shift(lr), .a(a_all[3*AW-1:0]),
    .delta(d_all[2*AW-1:0]), .w(w_all[6*WW-1:0]), .result(r1),
    .busy(busy_o[1]), .finish(fin_o[1]), .valid(val_o[1]), .sat(sat_o[1]));
  weight_updater_tiled #(.IN_NUM(3), .OUT_NUM(2), .LANES(6), .ROUND(1)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .lr_shift(lr), .a(a_all[3*AW-1:0]),
    .delta(d_all[2*AW-1:0]), .w(w_all[6*WW-1:0]), .result(r2),
    .busy(busy_o[2]), .finish(fin_o[2]), .valid(val_o[2]), .sat(sat_o[2]));
  weight_updater_tiled u3 (
    .clk(clk), .rst(rst), .start(start[3]), .lr_shift(lr), .a(a_all),
    .delta(d_all), .w(w_all), .result(r3),
    .busy(busy_o[3]), .finish(fin_o[3]), .valid(val_o[3]), .sat(sat_o[3]));

  assign res_o[0] = MAXW'(r0);
  assign res_o[1] = MAXW'(r1);
  assign res_o[2] = MAXW'(r2);
  assign res_o[3] = r3;

  // ---------------- reference model + scoreboard ----------------
  int              n_cmp = 0, n_err = 0;
  int              mcnt [NI];
  logic            m_fin[NI], m_val[NI], m_sat[NI];
  logic [MAXW-1:0] m_res[NI];
  logic [MAXW-1:0] q_res[NI][$];
  logic            q_sat[NI][$];

  function automatic void calc(input int g, output logic [MAXW-1:0] r, output logic s);
    longint av, dv, wv, p, d;
    r = '0;
    s = 1'b0;
    for (int k = 0; k < CIN[g]*COUT[g]; k++) begin
      av = longint'($signed(a_all[(k % CIN[g])*AW +: AW]));
      dv = longint'($signed(d_all[(k / CIN[g])*AW +: AW]));
      wv = longint'($signed(w_all[k*WW +: WW]));
      p  = av * dv;
      if (CR[g] == 1 && lr != 0) p = p + (longint'(1) << (lr - 1));
      p  = p >>> lr;
      d  = wv - p;
      if (d > SMAX)      begin d = SMAX; s = 1'b1; end
      else if (d < SMIN) begin d = SMIN; s = 1'b1; end
      r[k*WW +: WW] = d[WW-1:0];
    end
  endfunction

  task automatic chk1(input string nm, input int g, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s u%0d t=%0t: got %0b want %0b", nm, g, $time, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input int g, input logic [MAXW-1:0] act,
                      input logic [MAXW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s u%0d t=%0t: got %0h want %0h", nm, g, $time, act, exp);
    end
  endtask

  always begin
    logic [MAXW-1:0] er;
    logic            es;
    @(posedge clk);
    for (int g = 0; g < NI; g++) begin
      m_fin[g] = 1'b0;
      if (rst) begin
        mcnt[g] = 0; m_val[g] = 1'b0; m_sat[g] = 1'b0; m_res[g] = '0;
        q_res[g].delete(); q_sat[g].delete();
      end else if (mcnt[g] == 0 && start[g]) begin
        calc(g, er, es);
        q_res[g].push_back(er);
        q_sat[g].push_back(es);
        // busy for ceil(cells/lanes) issue cycles plus one drain cycle
        mcnt[g]  = (CIN[g]*COUT[g] + CL[g] - 1) / CL[g] + 1;
        m_val[g] = 1'b0;
      end else if (mcnt[g] > 0) begin
        mcnt[g]--;
        if (mcnt[g] == 0) begin m_fin[g] = 1'b1; m_val[g] = 1'b1; end
      end
    end
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk1("busy", g, busy_o[g], mcnt[g] != 0);
      chk1("finish", g, fin_o[g], m_fin[g]);
      chk1("valid", g, val_o[g], m_val[g]);
      if (fin_o[g]) begin
        if (q_res[g].size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL finish_unexpected u%0d t=%0t: got finish=1 want no pending op", g, $time);
        end else begin
          er = q_res[g].pop_front();
          es = q_sat[g].pop_front();
          chkv("result_at_finish", g, res_o[g], er);
          chk1("sat_at_finish", g, sat_o[g], es);
          m_res[g] = er;
          m_sat[g] = es;
        end
      end else if (mcnt[g] == 0) begin
        chkv("result_idle", g, res_o[g], m_res[g]);
        chk1("sat_idle", g, sat_o[g], m_sat[g]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int av, input int dv, input int wv);
    for (int j = 0; j < 5; j++)    a_all[j*AW +: AW] = AW'(av);
    for (int j = 0; j < 5; j++)    d_all[j*AW +: AW] = AW'(dv);
    for (int k = 0; k < MAXN; k++) w_all[k*WW +: WW] = WW'(wv);
  endtask

  task automatic rnd();
    for (int j = 0; j < 5; j++)    a_all[j*AW +: AW] = AW'($urandom);
    for (int j = 0; j < 5; j++)    d_all[j*AW +: AW] = AW'($urandom);
    for (int k = 0; k < MAXN; k++) w_all[k*WW +: WW] = WW'($urandom);
    lr = SW'($urandom);
  endtask

  task automatic go(input logic [NI-1:0] m, input int n);
    start = m;
    tick();
    start = '0;
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; start = '0; lr = '0; a_all = '0; d_all = '0; w_all = '0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // all cells: 100 - round(200 >>> 2) = 50
    fill(10, 20, 100); lr = 2;
    go(4'hF, 9);

    // negative clamp on cell 0
    fill(5, -3, 7); lr = 0;
    a_all[AW-1:0] = 8'd127; d_all[AW-1:0] = 8'd127; w_all[WW-1:0] = 16'h8000;
    go(4'hF, 9);
    // positive clamp on cell 0
    a_all[AW-1:0] = 8'h80; w_all[WW-1:0] = 16'h7FFF;
    go(4'hF, 9);

    // rounding vs floor, products +6 / -6, shift 2
    fill(2, 3, 0); lr = 2;
    go(4'h3, 8);
    fill(-2, 3, 0);
    go(4'h3, 8);

    // largest shift
    fill(-7, 9, 0); lr = 15;
    go(4'hF, 9);
    fill(7, 9, 3);
    go(4'hF, 9);

    // start while busy is dropped; start during the finish cycle is taken
    rnd(); start = 4'h3; tick();
    start = '0; rnd(); tick();
    start = 4'h3; tick();
    start = '0; tick();
    start = 4'h1; rnd(); tick();
    start = '0;
    repeat (9) tick();

    // reset mid-run aborts, then a fresh op completes
    rnd(); start = 4'hF; tick();
    start = '0; rst = 1'b1; tick();
    rst = 1'b0; tick();
    rnd(); go(4'hF, 9);

    // random traffic with overlapping starts and inputs changing while busy
    repeat (200) begin
      rnd();
      go(NI'($urandom_range(1, 15)), $urandom_range(0, 8));
    end
    repeat (10) tick();

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
